// File: rtl/serial_pkg.sv
// Shared types and helpers for the UART message transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_WAIT,
        SEQ_GAP
    } seq_state_t;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_START,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    // Number of bit times in one UART frame (start + 8 data + parity + stop).
    function automatic int unsigned frame_bits(input parity_t parity, input int unsigned stop_bits);
        return 32'd9 + stop_bits + ((parity != PARITY_NONE) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Single-character UART frame serialiser: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits. A start request arriving in the last
// stop-bit cycle chains the next frame with no idle cycle in between.
module uart_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 10,
    parameter parity_t     PARITY         = PARITY_NONE,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       frame_busy,
    output logic       frame_done
);

    localparam int unsigned    CNT_W     = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           PAR_INV   = (PARITY == PARITY_ODD);
    localparam logic           HAS_PAR   = (PARITY != PARITY_NONE);

    frame_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par;
    logic             bit_end;
    logic             accept;

    // Bit-time boundary, last-cycle-of-frame flag and start acceptance.
    assign bit_end    = (cnt == CNT_LAST);
    assign frame_done = (state == FR_STOP) && bit_end && (bit_cnt == STOP_LAST);
    assign frame_busy = (state != FR_IDLE);
    assign accept     = start && ((state == FR_IDLE) || frame_done);

    // Frame FSM with registered line output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FR_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else if (accept) begin
            state   <= FR_START;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= din;
            par     <= (^din) ^ PAR_INV;
            tx      <= 1'b0;
        end else if (state != FR_IDLE) begin
            if (!bit_end) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
                case (state)
                    FR_START: begin
                        state <= FR_DATA;
                        tx    <= shreg[0];
                    end
                    FR_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                state <= FR_PARITY;
                                tx    <= par;
                            end else begin
                                state <= FR_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                    FR_PARITY: begin
                        state   <= FR_STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                    FR_STOP: begin
                        if (bit_cnt == STOP_LAST) begin
                            state <= FR_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: begin
                        state <= FR_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/msg_tx.sv
// Message transmitter: on a trigger rising edge, sends MESSAGE one character
// per UART frame, with optional idle gap between characters and optional
// continuous repeat. Holds the edge detector, sequencer, gap counter and ROM.
module msg_tx
    import serial_pkg::*;
#(
    parameter int unsigned          CLOCKS_PER_BIT = 10,
    parameter int unsigned          MSG_LEN        = 12,
    parameter logic [8*MSG_LEN-1:0] MESSAGE        = "hello world\n",
    parameter parity_t              PARITY         = PARITY_NONE,
    parameter int unsigned          STOP_BITS      = 1,
    parameter int unsigned          GAP_BITS       = 0,
    localparam int unsigned         IDX_W          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             repeat_en,
    output logic             busy,
    output logic             tx,
    output logic [7:0]       data,
    output logic [IDX_W-1:0] index,
    output logic             done
);

    localparam int unsigned      GAP_CYC  = GAP_BITS * CLOCKS_PER_BIT;
    localparam int unsigned      GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
    localparam logic             HAS_GAP  = (GAP_CYC != 0);

    seq_state_t       state;
    logic             rst_meta;
    logic             rst_sync;
    logic             prev_trigger;
    logic             trig_edge;
    logic             last_char;
    logic             step;
    logic             start;
    logic [IDX_W-1:0] next_index;
    logic [7:0]       din;
    logic [GAP_W-1:0] gap_cnt;
    logic             frame_busy;
    logic             frame_done;

    // Character lookup; character 0 sits in the most significant byte.
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] i);
        logic [8*MSG_LEN-1:0] shifted;
        shifted = MESSAGE << (8 * i);
        return shifted[8*MSG_LEN-1 -: 8];
    endfunction

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {rst_sync, rst_meta} <= 2'b00;
        end else begin
            {rst_sync, rst_meta} <= {rst_meta, 1'b1};
        end
    end

    // Pass-step decode: a character slot (frame plus gap) ends this cycle.
    // Chained characters start straight from here so frames abut the gap.
    assign trig_edge  = trigger && !prev_trigger;
    assign last_char  = (index == IDX_LAST);
    assign step       = ((state == SEQ_WAIT) && frame_done && !HAS_GAP)
                     || ((state == SEQ_GAP) && (gap_cnt == GAP_LAST));
    assign start      = (state == SEQ_SEND) || (step && (!last_char || repeat_en));
    assign next_index = (state == SEQ_SEND) ? index
                      : (last_char ? '0 : index + IDX_W'(1));
    assign din        = char_at(next_index);
    assign data       = char_at(index);

    // Sequencer: edge detect, character stepping, gap timing, busy/done.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state        <= SEQ_IDLE;
            prev_trigger <= 1'b0;
            index        <= '0;
            gap_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            prev_trigger <= trigger;
            done         <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (trig_edge && !frame_busy) begin
                        state <= SEQ_SEND;
                        index <= '0;
                    end
                end
                SEQ_SEND: begin
                    busy  <= 1'b1;
                    state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (frame_done && HAS_GAP) begin
                        state   <= SEQ_GAP;
                        gap_cnt <= '0;
                    end
                end
                SEQ_GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
            if (step) begin
                if (!last_char) begin
                    index <= index + IDX_W'(1);
                    state <= SEQ_WAIT;
                end else begin
                    done <= 1'b1;
                    if (repeat_en) begin
                        index <= '0;
                        state <= SEQ_WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= SEQ_IDLE;
                    end
                end
            end
        end
    end

    // Frame serialiser.
    uart_tx #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
        .PARITY         (PARITY),
        .STOP_BITS      (STOP_BITS)
    ) u_uart_tx (
        .clk        (clk),
        .rst        (rst_sync),
        .start      (start),
        .din        (din),
        .tx         (tx),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_msg_tx.sv
// Directed bench for msg_tx: four instances ("Hi", 4 clocks/bit) covering
// 8N1, 8E1, 8O1 and 8N2 with a one-bit gap, sharing trigger/reset inputs.
module tb_msg_tx;
    import serial_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       trigger   = 1'b0;
    logic       repeat_en = 1'b0;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] index;
    logic [3:0][7:0] data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   dut;
        int   k;
        logic tx;
        logic busy;
        logic done;
        int   idx;
        int   dat;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] tr_tx   [0:127];
    logic [3:0] tr_busy [0:127];
    logic [3:0] tr_done [0:127];
    logic [3:0] tr_idx  [0:127];
    logic [7:0] tr_data [0:127];

    always #5 clk = ~clk;

    msg_tx #(.CLOCKS_PER_BIT(4), .MSG_LEN(2), .MESSAGE("Hi"), .PARITY(PARITY_NONE),
             .STOP_BITS(1), .GAP_BITS(0)) u0 (
        .clk(clk), .rst(rst), .trigger(trigger), .repeat_en(repeat_en),
        .busy(busy[0]), .tx(tx[0]), .data(data[0]), .index(index[0:0]), .done(done[0]));

    msg_tx #(.CLOCKS_PER_BIT(4), .MSG_LEN(2), .MESSAGE("Hi"), .PARITY(PARITY_EVEN),
             .STOP_BITS(1), .GAP_BITS(0)) u1 (
        .clk(clk), .rst(rst), .trigger(trigger), .repeat_en(repeat_en),
        .busy(busy[1]), .tx(tx[1]), .data(data[1]), .index(index[1:1]), .done(done[1]));

    msg_tx #(.CLOCKS_PER_BIT(4), .MSG_LEN(2), .MESSAGE("Hi"), .PARITY(PARITY_ODD),
             .STOP_BITS(1), .GAP_BITS(0)) u2 (
        .clk(clk), .rst(rst), .trigger(trigger), .repeat_en(repeat_en),
        .busy(busy[2]), .tx(tx[2]), .data(data[2]), .index(index[2:2]), .done(done[2]));

    msg_tx #(.CLOCKS_PER_BIT(4), .MSG_LEN(2), .MESSAGE("Hi"), .PARITY(PARITY_NONE),
             .STOP_BITS(2), .GAP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .trigger(trigger), .repeat_en(repeat_en),
        .busy(busy[3]), .tx(tx[3]), .data(data[3]), .index(index[3:3]), .done(done[3]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int d, input int k, input logic t, input logic b,
                                input logic dn, input int i, input int dat);
        vec_t v;
        v.dut = d; v.k = k; v.tx = t; v.busy = b; v.done = dn; v.idx = i; v.dat = dat;
        vecs.push_back(v);
    endfunction

    // Trigger pulse sampled at edge N; returns #1 after edge N (cycle k=0).
    task automatic fire();
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
    endtask

    task automatic record(input int k);
        tr_tx[7'(k)]   = tx;
        tr_busy[7'(k)] = busy;
        tr_done[7'(k)] = done;
        tr_idx[7'(k)]  = index;
        tr_data[7'(k)] = data[0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [0:9]  h_n;
        logic [0:9]  i_n;
        logic [0:10] h_e;
        logic [0:10] h_o;
        int nd0, nd3, d1k, d2k, fallk, wraps, bc0, bc3, late, bad;
        logic pb;
        logic pi;

        // Frame bit sequences in line order (start, d0..d7, [parity], stop).
        h_n = 10'b0000100101;   // 'H' 0x48
        i_n = 10'b0100101101;   // 'i' 0x69
        h_e = 11'b00001001001;  // 'H' even parity = 0
        h_o = 11'b00001001011;  // 'H' odd parity = 1

        // 8N1: pass of 80 cycles, done at 81.
        add(0, 0, 1'b1, 1'b0, 1'b0, 0, 'h48);
        add(0, 1, 1'b0, 1'b1, 1'b0, 0, -1);
        for (int b = 0; b < 10; b++) add(0, 4*b + 2, h_n[b], 1'b1, 1'b0, 0, 'h48);
        add(0, 40, 1'b1, 1'b1, 1'b0, 0, -1);
        add(0, 41, 1'b0, 1'b1, 1'b0, 1, 'h69);
        for (int b = 0; b < 10; b++) add(0, 40 + 4*b + 2, i_n[b], 1'b1, 1'b0, 1, 'h69);
        add(0, 80, 1'b1, 1'b1, 1'b0, 1, -1);
        add(0, 81, 1'b1, 1'b0, 1'b1, -1, -1);
        add(0, 82, 1'b1, 1'b0, 1'b0, -1, -1);
        // 8E1 / 8O1: 44-cycle frames.
        for (int b = 0; b < 11; b++) add(1, 4*b + 2, h_e[b], 1'b1, 1'b0, 0, -1);
        for (int b = 0; b < 11; b++) add(2, 4*b + 2, h_o[b], 1'b1, 1'b0, 0, -1);
        add(1, 44, 1'b1, 1'b1, 1'b0, 0, -1);
        add(1, 45, 1'b0, 1'b1, 1'b0, 1, -1);
        add(1, 82, 1'b0, 1'b1, 1'b0, 1, -1);
        add(1, 88, 1'b1, 1'b1, 1'b0, 1, -1);
        add(1, 89, 1'b1, 1'b0, 1'b1, -1, -1);
        add(2, 45, 1'b0, 1'b1, 1'b0, 1, -1);
        add(2, 82, 1'b1, 1'b1, 1'b0, 1, -1);
        add(2, 89, 1'b1, 1'b0, 1'b1, -1, -1);
        // 8N2 + 1 gap bit: 12 idle-high cycles, pitch 48, pass 96.
        add(3, 36, 1'b0, 1'b1, 1'b0, 0, -1);
        for (int k = 37; k <= 48; k++) add(3, k, 1'b1, 1'b1, 1'b0, 0, -1);
        add(3, 49, 1'b0, 1'b1, 1'b0, 1, -1);
        add(3, 54, 1'b1, 1'b1, 1'b0, 1, -1);
        add(3, 96, 1'b1, 1'b1, 1'b0, 1, -1);
        add(3, 97, 1'b1, 1'b0, 1'b1, -1, -1);
        add(3, 98, 1'b1, 1'b0, 1'b0, -1, -1);

        // Reset state.
        #12;
        chk("reset tx", int'(tx), 4'hF);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset index", int'(index), 0);
        chk("reset data", int'(data[0]), 'h48);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post-release tx", int'(tx), 4'hF);
        chk("post-release busy", int'(busy), 0);

        // Single pass on all instances, compared against the vector table.
        fire();
        record(0);
        for (int k = 1; k < 128; k++) begin
            @(posedge clk);
            #1;
            record(k);
        end
        foreach (vecs[n]) begin
            automatic vec_t v = vecs[n];
            automatic logic [6:0] kk = 7'(v.k);
            automatic logic [1:0] d = 2'(v.dut);
            chk($sformatf("u%0d k%0d tx", v.dut, v.k), int'(tr_tx[kk][d]), int'(v.tx));
            chk($sformatf("u%0d k%0d busy", v.dut, v.k), int'(tr_busy[kk][d]), int'(v.busy));
            chk($sformatf("u%0d k%0d done", v.dut, v.k), int'(tr_done[kk][d]), int'(v.done));
            if (v.idx >= 0)
                chk($sformatf("u%0d k%0d index", v.dut, v.k), int'(tr_idx[kk][d]), v.idx);
            if (v.dat >= 0)
                chk($sformatf("u%0d k%0d data", v.dut, v.k), int'(tr_data[kk]), v.dat);
        end

        // Repeat mode: two passes, repeat_en cleared during the second.
        repeat (10) @(posedge clk);
        repeat_en = 1'b1;
        fire();
        nd0 = 0; nd3 = 0; d1k = -1; d2k = -1; fallk = -1; wraps = 0;
        pb = busy[0];
        pi = index[0];
        for (int k = 1; k < 260; k++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                nd0++;
                if (nd0 == 1) begin
                    d1k = k;
                    chk("repeat start bit on done", int'(tx[0]), 0);
                    chk("repeat busy on done", int'(busy[0]), 1);
                    chk("repeat index on done", int'(index[0]), 0);
                end else begin
                    d2k = k;
                end
            end
            if (done[3]) nd3++;
            if (pb && !busy[0]) fallk = k;
            if (pi && !index[0]) wraps++;
            pb = busy[0];
            pi = index[0];
            if (k == 100) repeat_en = 1'b0;
        end
        chk("repeat done count", nd0, 2);
        chk("repeat first done cycle", d1k, 81);
        chk("repeat second done cycle", d2k, 161);
        chk("repeat busy fall cycle", fallk, 161);
        chk("repeat index wraps", wraps, 1);
        chk("repeat gap done count", nd3, 2);

        // Re-trigger while busy, then trigger held high past pass end.
        repeat (10) @(posedge clk);
        fire();
        nd0 = 0; bc0 = 0; bc3 = 0; late = 0;
        for (int k = 1; k < 250; k++) begin
            @(posedge clk);
            #1;
            if (done[0]) nd0++;
            if (busy[0]) bc0++;
            if (busy[3]) bc3++;
            if (k >= 100 && busy != 4'h0) late++;
            if (k == 20) trigger = 1'b1;
            if (k == 21) trigger = 1'b0;
            if (k == 60) trigger = 1'b1;
        end
        trigger = 1'b0;
        chk("retrigger done count", nd0, 1);
        chk("retrigger busy cycles 8N1", bc0, 80);
        chk("retrigger busy cycles 8N2 gap", bc3, 96);
        chk("held trigger extra pass", late, 0);

        // Reset asserted in the middle of the data bits.
        repeat (10) @(posedge clk);
        fire();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
        end
        chk("pre-reset busy", int'(busy[0]), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset tx", int'(tx), 4'hF);
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset index", int'(index), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (tx != 4'hF || busy != 4'h0) bad++;
        end
        chk("no partial frame after reset", bad, 0);
        fire();
        for (int k = 1; k < 90; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("after reset start bit", int'(tx[0]), 0);
            if (k == 2) chk("after reset index", int'(index[0]), 0);
            if (k == 2) chk("after reset data", int'(data[0]), 'h48);
            if (k == 18) chk("after reset H d3", int'(tx[0]), 1);
            if (k == 41) chk("after reset second char index", int'(index[0]), 1);
            if (k == 81) chk("after reset done", int'(done[0]), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
